// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver, data bits MSB first.
//
// Recovers bytes from an asynchronous serial line that idles high. A frame is
// one low start bit, eight data bits (first one lands in DATA_OUT[7]) and one
// high stop bit, each CLKS_PER_BIT clocks long. Every bit is sampled once, at
// its middle, counted from the detected start edge.
//
// Ports
//   CLK        input   1  system clock, rising edge
//   RST_N      input   1  synchronous reset, active low
//   RX_EN      input   1  receive enable, only looked at while idle
//   RX_IN      input   1  asynchronous serial line
//   DATA_OUT   output  8  last good byte, held until the next good frame
//   VALID      output  1  one-cycle pulse, DATA_OUT just updated
//   FRAME_ERR  output  1  one-cycle pulse, stop bit sampled low
//   BUSY       output  1  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX_EN,
  input  logic       RX_IN,
  output logic [7:0] DATA_OUT,
  output logic       VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t BIT_LAST  = cnt_t'(CLKS_PER_BIT - 1);
  localparam cnt_t HALF_LAST = cnt_t'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  logic       rx_meta_q;
  logic       rx_s_q;
  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       busy_q, busy_d;

  // Two-flop synchronizer; resets to the idle (high) line level so a reset
  // can never look like a start edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and output logic of the frame FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = 3'd0;
        // Level check rather than edge: a line already low when RX_EN rises
        // is treated as a start bit.
        if (RX_EN && !rx_s_q) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          // Line back high at mid start bit means it was only a glitch.
          if (!rx_s_q) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {shift_q[6:0], rx_s_q};
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      S_BREAK: begin
        // Hold off until the line recovers so a long break flags only once.
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = 3'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign DATA_OUT  = data_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;
  assign BUSY      = busy_q;

endmodule
